// File: rtl/ctrl_mc_exc.sv
// Multi-cycle MIPS control FSM with precise exceptions for signed overflow, illegal
// opcode/funct and memory bus timeout. Outputs decode the registered state combinationally.
module ctrl_mc_exc #(
    parameter int MIO_TIMEOUT = 16,
    parameter int OVF_TRAP    = 1,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_in,
    input  logic        zero,
    input  logic        overflow,
    input  logic        MIO_ready,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [3:0]  ALU_operation,
    output logic [4:0]  state_out,
    output logic        EPCWrite,
    output logic        CauseWrite,
    output logic [1:0]  Cause
);

    typedef enum logic [4:0] {
        S_IF      = 5'd0,
        S_ID      = 5'd1,
        S_MEM_EX  = 5'd2,
        S_MEM_RD  = 5'd3,
        S_LW_WB   = 5'd4,
        S_MEM_WD  = 5'd5,
        S_R_EXE   = 5'd6,
        S_R_WB    = 5'd7,
        S_BEQ_EXE = 5'd8,
        S_J       = 5'd9,
        S_I_EXE   = 5'd10,
        S_I_WB    = 5'd11,
        S_LUI_WB  = 5'd12,
        S_BNE_EXE = 5'd13,
        S_JR      = 5'd14,
        S_JAL     = 5'd15,
        S_SH_EXE  = 5'd16,
        S_EXC     = 5'd17
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_OVF     = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    localparam bit            TO_EN    = (MIO_TIMEOUT != 0);
    localparam bit            OVF_EN   = (OVF_TRAP != 0);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MIO_TIMEOUT);
    localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

    state_t          state;
    state_t          next_state;
    logic [1:0]      next_cause;
    logic [1:0]      cause_q;
    logic [TO_W-1:0] wait_cnt;
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [3:0]      r_alu_op;
    logic [3:0]      i_alu_op;
    logic            r_funct_ok;
    logic            r_is_addsub;
    logic            waiting;
    logic            timeout_hit;
    logic            unused_inputs;

    assign opcode        = Inst_in[31:26];
    assign funct         = Inst_in[5:0];
    assign unused_inputs = ^{Inst_in[25:6], zero};
    assign state_out     = state;

    // R-type funct decode: ALU operation and whether the funct is one we implement
    always_comb begin
        r_alu_op   = ALU_AND;
        r_funct_ok = 1'b1;
        case (funct)
            F_ADD:   r_alu_op = ALU_ADD;
            F_SUB:   r_alu_op = ALU_SUB;
            F_AND:   r_alu_op = ALU_AND;
            F_OR:    r_alu_op = ALU_OR;
            F_XOR:   r_alu_op = ALU_XOR;
            F_NOR:   r_alu_op = ALU_NOR;
            F_SLT:   r_alu_op = ALU_SLT;
            F_SLTU:  r_alu_op = ALU_SLTU;
            F_SLLV:  r_alu_op = ALU_SLL;
            F_SRLV:  r_alu_op = ALU_SRL;
            F_SLL:   r_alu_op = ALU_SLL;
            F_SRL:   r_alu_op = ALU_SRL;
            F_SRA:   r_alu_op = ALU_SRA;
            F_JR:    r_alu_op = ALU_ADD;
            default: r_funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        i_alu_op = ALU_AND;
        case (opcode)
            OP_ADDI:  i_alu_op = ALU_ADD;
            OP_ANDI:  i_alu_op = ALU_AND;
            OP_ORI:   i_alu_op = ALU_OR;
            OP_XORI:  i_alu_op = ALU_XOR;
            OP_SLTI:  i_alu_op = ALU_SLT;
            OP_SLTIU: i_alu_op = ALU_SLTU;
            default:  i_alu_op = ALU_AND;
        endcase
    end

    assign r_is_addsub = (funct == F_ADD) || (funct == F_SUB);
    assign waiting     = ((state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WD)) && !MIO_ready;
    assign timeout_hit = TO_EN && waiting && ((wait_cnt + CNT_ONE) == TO_LIMIT);

    always_comb begin
        next_state = state;
        next_cause = CAUSE_NONE;
        case (state)
            S_IF: begin
                if (MIO_ready) begin
                    next_state = S_ID;
                end else if (timeout_hit) begin
                    next_state = S_EXC;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_ID: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (!r_funct_ok) begin
                            next_state = S_EXC;
                            next_cause = CAUSE_ILLEGAL;
                        end else if (funct == F_JR) begin
                            next_state = S_JR;
                        end else if ((funct == F_SLL) || (funct == F_SRL) || (funct == F_SRA)) begin
                            next_state = S_SH_EXE;
                        end else begin
                            next_state = S_R_EXE;
                        end
                    end
                    OP_J:     next_state = S_J;
                    OP_JAL:   next_state = S_JAL;
                    OP_BEQ:   next_state = S_BEQ_EXE;
                    OP_BNE:   next_state = S_BNE_EXE;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU:
                              next_state = S_I_EXE;
                    OP_LUI:   next_state = S_LUI_WB;
                    OP_LW, OP_SW:
                              next_state = S_MEM_EX;
                    default: begin
                        next_state = S_EXC;
                        next_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_EX: next_state = (opcode == OP_SW) ? S_MEM_WD : S_MEM_RD;
            S_MEM_RD, S_MEM_WD: begin
                if (MIO_ready) begin
                    next_state = (state == S_MEM_RD) ? S_LW_WB : S_IF;
                end else if (timeout_hit) begin
                    next_state = S_EXC;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_R_EXE: begin
                if (OVF_EN && overflow && r_is_addsub) begin
                    next_state = S_EXC;
                    next_cause = CAUSE_OVF;
                end else begin
                    next_state = S_R_WB;
                end
            end
            S_SH_EXE: next_state = S_R_WB;
            S_I_EXE: begin
                if (OVF_EN && overflow && (opcode == OP_ADDI)) begin
                    next_state = S_EXC;
                    next_cause = CAUSE_OVF;
                end else begin
                    next_state = S_I_WB;
                end
            end
            default: next_state = S_IF;
        endcase
    end

    // Wait counter runs only while a memory handshake is stalled; any other cycle clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IF;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_EXC) begin
                cause_q <= next_cause;
            end
            if (waiting && (next_state != S_EXC)) begin
                wait_cnt <= wait_cnt + CNT_ONE;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        CPU_MIO       = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_operation = ALU_AND;
        EPCWrite      = 1'b0;
        CauseWrite    = 1'b0;
        Cause         = CAUSE_NONE;
        case (state)
            S_IF: begin
                MemRead       = 1'b1;
                CPU_MIO       = 1'b1;
                ALUSrcB       = 2'b01;
                ALU_operation = ALU_ADD;
                IRWrite       = MIO_ready;
                PCWrite       = MIO_ready;
            end
            S_ID: begin
                ALUSrcB       = 2'b11;
                ALU_operation = ALU_ADD;
            end
            S_MEM_EX: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = ALU_ADD;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
            end
            S_LW_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEM_WD: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                CPU_MIO  = 1'b1;
            end
            S_R_EXE: begin
                ALUSrcA       = 1'b1;
                ALU_operation = r_alu_op;
            end
            S_SH_EXE: begin
                ALUSrcB       = 2'b10;
                RegDst        = 2'b11;
                ALU_operation = r_alu_op;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_I_EXE: begin
                ALUSrcA       = 1'b1;
                ALUSrcB       = 2'b10;
                ALU_operation = i_alu_op;
            end
            S_I_WB:   RegWrite = 1'b1;
            S_LUI_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
            end
            S_BEQ_EXE, S_BNE_EXE: begin
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
                Branch        = (state == S_BEQ_EXE);
            end
            S_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b11;
            end
            S_JR: begin
                PCWrite       = 1'b1;
                ALUSrcA       = 1'b1;
                ALU_operation = ALU_ADD;
            end
            S_EXC: begin
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                Cause      = cause_q;
            end
            default: begin
                MemRead = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_mc_exc.sv
// Randomized self-checking bench for ctrl_mc_exc: each instruction is expanded into the
// expected per-cycle state path, then driven cycle by cycle and compared against the DUT.
module tb_ctrl_mc_exc;

    localparam int TIMEOUT = 4;

    localparam logic [4:0] ST_IF = 5'd0, ST_ID = 5'd1, ST_MEM_EX = 5'd2, ST_MEM_RD = 5'd3,
                           ST_LW_WB = 5'd4, ST_MEM_WD = 5'd5, ST_R_EXE = 5'd6, ST_R_WB = 5'd7,
                           ST_BEQ = 5'd8, ST_J = 5'd9, ST_I_EXE = 5'd10, ST_I_WB = 5'd11,
                           ST_LUI_WB = 5'd12, ST_BNE = 5'd13, ST_JR = 5'd14, ST_JAL = 5'd15,
                           ST_SH_EXE = 5'd16, ST_EXC = 5'd17;

    localparam logic [3:0] A_AND = 4'd0, A_OR = 4'd1, A_ADD = 4'd2, A_XOR = 4'd3, A_NOR = 4'd4,
                           A_SRL = 4'd5, A_SUB = 4'd6, A_SLTU = 4'd7, A_SLL = 4'd8,
                           A_SLT = 4'd9, A_SRA = 4'd10;

    typedef enum int {
        C_RARITH, C_SHIFT, C_JR, C_J, C_JAL, C_BEQ, C_BNE, C_IMM, C_LUI, C_LW, C_SW, C_ILLEGAL
    } iclass_t;

    typedef struct {
        logic [4:0]  st;
        logic [31:0] inst;
        bit          rdy;
        bit          ovf;
        logic [1:0]  cause;
    } step_t;

    logic        clk;
    logic        reset;
    logic [31:0] Inst_in;
    logic        zero;
    logic        overflow;
    logic        MIO_ready;
    logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite;
    logic        PCWriteCond, Branch, EPCWrite, CauseWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource, Cause;
    logic [3:0]  ALU_operation;
    logic [4:0]  state_out;
    logic [25:0] act_vec;

    int    checks   = 0;
    int    failures = 0;
    step_t plan_q[$];

    logic [5:0] rfuncts   [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h04, 6'h06};
    logic [5:0] sfuncts   [3]  = '{6'h00, 6'h02, 6'h03};
    logic [5:0] iops      [6]  = '{6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
    logic [5:0] bad_ops   [5]  = '{6'h01, 6'h09, 6'h10, 6'h20, 6'h3F};
    logic [5:0] bad_functs[5]  = '{6'h01, 6'h05, 6'h21, 6'h23, 6'h3F};

    ctrl_mc_exc #(.MIO_TIMEOUT(TIMEOUT), .OVF_TRAP(1), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
        .MIO_ready(MIO_ready), .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO),
        .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALU_operation(ALU_operation), .state_out(state_out), .EPCWrite(EPCWrite),
        .CauseWrite(CauseWrite), .Cause(Cause)
    );

    assign act_vec = {MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA, PCWrite,
                      PCWriteCond, Branch, EPCWrite, CauseWrite, RegDst, MemtoReg, ALUSrcB,
                      PCSource, ALU_operation, Cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit rbit();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h20: return A_ADD;   6'h22: return A_SUB;  6'h24: return A_AND;
            6'h25: return A_OR;    6'h26: return A_XOR;  6'h27: return A_NOR;
            6'h2A: return A_SLT;   6'h2B: return A_SLTU; 6'h04: return A_SLL;
            6'h06: return A_SRL;   6'h00: return A_SLL;  6'h02: return A_SRL;
            6'h03: return A_SRA;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic [3:0] imm_alu(input logic [5:0] op);
        case (op)
            6'h08: return A_ADD;  6'h0A: return A_SLT; 6'h0B: return A_SLTU;
            6'h0C: return A_AND;  6'h0D: return A_OR;  6'h0E: return A_XOR;
            default: return A_AND;
        endcase
    endfunction

    // Expected control word for one state, straight from the per-state output table
    function automatic logic [25:0] exp_out(input logic [4:0] st, input logic [31:0] inst,
                                            input bit rdy, input logic [1:0] cause);
        logic mr = 0, mw = 0, mio = 0, iord = 0, irw = 0, rw = 0, sa = 0, pcw = 0;
        logic pcc = 0, br = 0, epc = 0, cw = 0;
        logic [1:0] rd = 0, m2r = 0, sb = 0, pcs = 0, c = 0;
        logic [3:0] alu = A_AND;
        case (st)
            ST_IF:     begin mr = 1; mio = 1; sb = 2'b01; alu = A_ADD; irw = rdy; pcw = rdy; end
            ST_ID:     begin sb = 2'b11; alu = A_ADD; end
            ST_MEM_EX: begin sa = 1; sb = 2'b10; alu = A_ADD; end
            ST_MEM_RD: begin iord = 1; mr = 1; mio = 1; end
            ST_LW_WB:  begin rw = 1; m2r = 2'b01; end
            ST_MEM_WD: begin iord = 1; mw = 1; mio = 1; end
            ST_R_EXE:  begin sa = 1; alu = funct_alu(inst[5:0]); end
            ST_SH_EXE: begin sb = 2'b10; rd = 2'b11; alu = funct_alu(inst[5:0]); end
            ST_R_WB:   begin rw = 1; rd = 2'b01; end
            ST_I_EXE:  begin sa = 1; sb = 2'b10; alu = imm_alu(inst[31:26]); end
            ST_I_WB:   rw = 1;
            ST_LUI_WB: begin rw = 1; m2r = 2'b10; end
            ST_BEQ:    begin sa = 1; alu = A_SUB; pcc = 1; pcs = 2'b01; br = 1; end
            ST_BNE:    begin sa = 1; alu = A_SUB; pcc = 1; pcs = 2'b01; end
            ST_J:      begin pcw = 1; pcs = 2'b10; end
            ST_JAL:    begin pcw = 1; pcs = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b11; end
            ST_JR:     begin pcw = 1; sa = 1; alu = A_ADD; end
            ST_EXC:    begin epc = 1; cw = 1; pcw = 1; pcs = 2'b11; c = cause; end
            default:   c = 2'b00;
        endcase
        return {mr, mw, mio, iord, irw, rw, sa, pcw, pcc, br, epc, cw, rd, m2r, sb, pcs, alu, c};
    endfunction

    function automatic void push_step(input logic [4:0] st, input logic [31:0] inst,
                                      input bit rdy, input bit ovf, input logic [1:0] cause);
        step_t s;
        s.st = st; s.inst = inst; s.rdy = rdy; s.ovf = ovf; s.cause = cause;
        plan_q.push_back(s);
    endfunction

    // A memory handshake stalled w cycles; returns 1 when the stall ends in a timeout trap
    function automatic bit add_wait(input logic [4:0] st, input logic [31:0] inst, input int w);
        if (TIMEOUT != 0 && w >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT; i++) push_step(st, inst, 1'b0, rbit(), 2'b00);
            push_step(ST_EXC, inst, rbit(), rbit(), 2'b11);
            return 1'b1;
        end
        for (int i = 0; i < w; i++) push_step(st, inst, 1'b0, rbit(), 2'b00);
        push_step(st, inst, 1'b1, rbit(), 2'b00);
        return 1'b0;
    endfunction

    function automatic void plan_instr(input iclass_t cls, input logic [31:0] inst,
                                       input int fw, input int mw, input bit ovf);
        if (add_wait(ST_IF, inst, fw)) return;
        push_step(ST_ID, inst, rbit(), rbit(), 2'b00);
        case (cls)
            C_RARITH: begin
                push_step(ST_R_EXE, inst, rbit(), ovf, 2'b00);
                if (ovf && (inst[5:0] == 6'h20 || inst[5:0] == 6'h22))
                    push_step(ST_EXC, inst, rbit(), rbit(), 2'b01);
                else
                    push_step(ST_R_WB, inst, rbit(), rbit(), 2'b00);
            end
            C_SHIFT: begin
                push_step(ST_SH_EXE, inst, rbit(), ovf, 2'b00);
                push_step(ST_R_WB, inst, rbit(), rbit(), 2'b00);
            end
            C_IMM: begin
                push_step(ST_I_EXE, inst, rbit(), ovf, 2'b00);
                if (ovf && inst[31:26] == 6'h08)
                    push_step(ST_EXC, inst, rbit(), rbit(), 2'b01);
                else
                    push_step(ST_I_WB, inst, rbit(), rbit(), 2'b00);
            end
            C_JR:   push_step(ST_JR, inst, rbit(), rbit(), 2'b00);
            C_J:    push_step(ST_J, inst, rbit(), rbit(), 2'b00);
            C_JAL:  push_step(ST_JAL, inst, rbit(), rbit(), 2'b00);
            C_BEQ:  push_step(ST_BEQ, inst, rbit(), rbit(), 2'b00);
            C_BNE:  push_step(ST_BNE, inst, rbit(), rbit(), 2'b00);
            C_LUI:  push_step(ST_LUI_WB, inst, rbit(), rbit(), 2'b00);
            C_LW: begin
                push_step(ST_MEM_EX, inst, rbit(), rbit(), 2'b00);
                if (!add_wait(ST_MEM_RD, inst, mw)) push_step(ST_LW_WB, inst, rbit(), rbit(), 2'b00);
            end
            C_SW: begin
                push_step(ST_MEM_EX, inst, rbit(), rbit(), 2'b00);
                void'(add_wait(ST_MEM_WD, inst, mw));
            end
            default: push_step(ST_EXC, inst, rbit(), rbit(), 2'b10);
        endcase
    endfunction

    function automatic logic [31:0] gen_instr(input iclass_t cls);
        logic [31:0] inst;
        inst = $urandom;
        case (cls)
            C_RARITH: begin inst[31:26] = 6'h00; inst[5:0] = rfuncts[$urandom_range(0, 9)]; end
            C_SHIFT:  begin inst[31:26] = 6'h00; inst[5:0] = sfuncts[$urandom_range(0, 2)]; end
            C_JR:     begin inst[31:26] = 6'h00; inst[5:0] = 6'h08; end
            C_J:      inst[31:26] = 6'h02;
            C_JAL:    inst[31:26] = 6'h03;
            C_BEQ:    inst[31:26] = 6'h04;
            C_BNE:    inst[31:26] = 6'h05;
            C_IMM:    inst[31:26] = iops[$urandom_range(0, 5)];
            C_LUI:    inst[31:26] = 6'h0F;
            C_LW:     inst[31:26] = 6'h23;
            C_SW:     inst[31:26] = 6'h2B;
            default: begin
                if (rbit()) begin
                    inst[31:26] = 6'h00;
                    inst[5:0]   = bad_functs[$urandom_range(0, 4)];
                end else begin
                    inst[31:26] = bad_ops[$urandom_range(0, 4)];
                end
            end
        endcase
        return inst;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] inst, input bit rdy, input bit ovf);
        @(negedge clk);
        Inst_in   = inst;
        MIO_ready = rdy;
        overflow  = ovf;
        zero      = rbit();
    endtask

    task automatic runPlan();
        step_t s;
        while (plan_q.size() > 0) begin
            s = plan_q.pop_front();
            applyStimulus(s.inst, s.rdy, s.ovf);
            #1;
            checkOutput("state", 32'(state_out), 32'(s.st));
            checkOutput("outputs", 32'(act_vec), 32'(exp_out(s.st, s.inst, s.rdy, s.cause)));
        end
    endtask

    initial begin
        iclass_t cls;
        logic [31:0] inst;
        reset = 1'b1; Inst_in = '0; MIO_ready = 1'b0; overflow = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        applyStimulus(32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_state", 32'(state_out), 32'(ST_IF));
        checkOutput("reset_outputs", 32'(act_vec), 32'(exp_out(ST_IF, 32'h0, 1'b0, 2'b00)));
        applyStimulus(32'h0, 1'b1, 1'b0);
        #1;
        checkOutput("reset_if_ready", 32'(act_vec), 32'(exp_out(ST_IF, 32'h0, 1'b1, 2'b00)));
        @(posedge clk);
        #1;
        reset = 1'b0;

        plan_instr(C_RARITH, 32'h00221820, 0, 0, 1'b0);
        plan_instr(C_LW, 32'h8C220004, 0, 3, 1'b0);
        plan_instr(C_IMM, 32'h20220001, 0, 0, 1'b1);
        plan_instr(C_J, 32'h08000010, 4, 0, 1'b0);
        plan_instr(C_ILLEGAL, 32'hFC000000, 0, 0, 1'b0);
        plan_instr(C_SHIFT, 32'h00021843, 1, 0, 1'b1);
        plan_instr(C_SW, 32'hAC220008, 3, 4, 1'b0);
        plan_instr(C_LW, 32'h8C220004, 0, 3, 1'b0);
        plan_instr(C_RARITH, 32'h00221822, 0, 0, 1'b1);
        runPlan();

        for (int n = 0; n < 200; n++) begin
            cls  = iclass_t'($urandom_range(0, 11));
            inst = gen_instr(cls);
            plan_instr(cls, inst, $urandom_range(0, 5), $urandom_range(0, 5),
                       ($urandom_range(0, 3) == 0));
            runPlan();
        end

        // Reset in the middle of a stalled store; the stall count must not survive the reset
        inst = 32'hAC010000;
        push_step(ST_IF, inst, 1'b1, 1'b0, 2'b00);
        push_step(ST_ID, inst, 1'b0, 1'b0, 2'b00);
        push_step(ST_MEM_EX, inst, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) push_step(ST_MEM_WD, inst, 1'b0, 1'b0, 2'b00);
        runPlan();
        applyStimulus(inst, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("pre_reset_memwrite", 32'(MemWrite), 32'd1);
        applyStimulus(inst, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_state", 32'(state_out), 32'(ST_IF));
        checkOutput("post_reset_outputs", 32'(act_vec), 32'(exp_out(ST_IF, inst, 1'b0, 2'b00)));
        plan_instr(C_LUI, 32'h3C011234, 2, 0, 1'b0);
        runPlan();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
